// File: rtl/bounds_pkg.sv
// Shared types for the bounds-tracking record writer: command ops, error codes,
// the queued record format and the FSM state encoding.
package bounds_pkg;

   typedef enum logic [1:0] {
      SET_FIRST = 2'd0,
      SET_LAST  = 2'd1,
      SET_SIZE  = 2'd2,
      ABORT     = 2'd3
   } cmd_op_e;

   typedef enum logic [1:0] {
      NONE         = 2'd0,
      NO_FIRST     = 2'd1,
      INVERTED     = 2'd2,
      ZERO_OR_WRAP = 2'd3
   } err_code_e;

   typedef enum logic {
      IDLE       = 1'b0,
      HAVE_FIRST = 1'b1
   } wr_state_e;

   typedef struct packed {
      logic [31:0] first;
      logic [31:0] last;
      logic        is_big;
   } bounds_rec_t;

   localparam logic [31:0] DEFAULT_BIG_BYTES = 32'd4096;

   // Byte length (last-first+1) > big_bytes, folded so it never needs 33 bits.
   function automatic logic range_is_big(input logic [31:0] first,
                                         input logic [31:0] last,
                                         input logic [31:0] big_bytes);
      return (last - first) >= big_bytes;
   endfunction

endpackage

// File: rtl/bounds_rec_fifo.sv
// Synchronous record FIFO; extra pointer bit separates full from empty.
module bounds_rec_fifo
   import bounds_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        push_i,
   input  bounds_rec_t data_i,
   input  logic        pop_i,
   output bounds_rec_t data_o,
   output logic        full_o,
   output logic        empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   bounds_rec_t    mem_q [DEPTH];
   logic [AW:0]    wr_ptr_q;
   logic [AW:0]    rd_ptr_q;
   logic           do_push;
   logic           do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
            wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/bounds_record_writer.sv
// Descriptor assembler: validates first/last/size commands, queues bounds
// records and streams them to the circular buffer with error accounting.
module bounds_record_writer
   import bounds_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [31:0] BIG_BYTES  = DEFAULT_BIG_BYTES,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [1:0]       cmd_op_i,
   input  logic [31:0]      cmd_data_i,
   input  logic             wr_ready_i,
   output logic             en_write_o,
   output logic             rec_valid_o,
   output logic [31:0]      addr_first_o,
   output logic [31:0]      addr_last_o,
   output logic             is_big_o,
   output logic             busy_o,
   output logic             err_o,
   output logic [1:0]       err_code_o,
   output logic [CNT_W-1:0] rec_count_o,
   output logic [CNT_W-1:0] drop_count_o
);

   wr_state_e        state_q, state_d;
   logic [31:0]      first_q, first_d;
   logic             err_q, err_d;
   err_code_e        err_code_q, err_code_d;
   logic [CNT_W-1:0] rec_cnt_q, drop_cnt_q;
   bounds_rec_t      hold_q;

   logic             accept;
   logic             push;
   bounds_rec_t      push_rec;
   bounds_rec_t      head;
   bounds_rec_t      head_out;
   logic             full, empty, pop;
   logic [32:0]      size_last;

   assign cmd_ready_o = ~full;
   assign accept      = cmd_valid_i & ~full;
   assign pop         = ~empty & wr_ready_i;
   assign en_write_o  = pop;
   assign rec_valid_o = ~empty;
   assign busy_o      = (state_q == HAVE_FIRST) | ~empty;
   assign err_o       = err_q;
   assign err_code_o  = err_code_q;
   assign rec_count_o  = rec_cnt_q;
   assign drop_count_o = drop_cnt_q;

   // Head is held at the last popped record while the queue is empty.
   assign head_out     = empty ? hold_q : head;
   assign addr_first_o = head_out.first;
   assign addr_last_o  = head_out.last;
   assign is_big_o     = head_out.is_big;

   assign size_last = {1'b0, first_q} + {1'b0, cmd_data_i} - 33'd1;

   always_comb begin
      state_d    = state_q;
      first_d    = first_q;
      err_d      = 1'b0;
      err_code_d = err_code_q;
      push       = 1'b0;
      push_rec   = '0;
      if (accept) begin
         unique case (cmd_op_e'(cmd_op_i))
            SET_FIRST: begin
               first_d = cmd_data_i;
               state_d = HAVE_FIRST;
            end
            SET_LAST: begin
               state_d = IDLE;
               if (state_q != HAVE_FIRST) begin
                  err_d      = 1'b1;
                  err_code_d = NO_FIRST;
               end else if (cmd_data_i < first_q) begin
                  err_d      = 1'b1;
                  err_code_d = INVERTED;
               end else begin
                  push           = 1'b1;
                  push_rec.first = first_q;
                  push_rec.last  = cmd_data_i;
               end
            end
            SET_SIZE: begin
               state_d = IDLE;
               if (state_q != HAVE_FIRST) begin
                  err_d      = 1'b1;
                  err_code_d = NO_FIRST;
               end else if ((cmd_data_i == '0) || size_last[32]) begin
                  err_d      = 1'b1;
                  err_code_d = ZERO_OR_WRAP;
               end else begin
                  push           = 1'b1;
                  push_rec.first = first_q;
                  push_rec.last  = size_last[31:0];
               end
            end
            default: state_d = IDLE;
         endcase
      end
      push_rec.is_big = range_is_big(push_rec.first, push_rec.last, BIG_BYTES);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         first_q    <= '0;
         err_q      <= 1'b0;
         err_code_q <= NONE;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         first_q    <= first_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         if (err_d && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rec_cnt_q <= '0;
         hold_q    <= '0;
      end else if (pop) begin
         hold_q <= head;
         if (rec_cnt_q != '1) begin
            rec_cnt_q <= rec_cnt_q + CNT_W'(1);
         end
      end
   end

   bounds_rec_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .data_i  (push_rec),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

endmodule

// File: tb/tb_bounds_record_writer.sv
// Randomized and directed bench for bounds_record_writer against a queue-based
// reference model of descriptor assembly and record delivery.
module tb_bounds_record_writer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [1:0]  cmd_op = 2'd0;
   logic [31:0] cmd_data = '0;
   logic        wr_ready = 1'b0;
   int          wr_mode = 0;

   logic        cmd_ready_o, en_write_o, rec_valid_o, is_big_o, busy_o, err_o;
   logic [31:0] addr_first_o, addr_last_o;
   logic [1:0]  err_code_o;
   logic [15:0] rec_count_o, drop_count_o;

   int n_checks = 0;
   int n_errs   = 0;

   bounds_record_writer #(
      .FIFO_DEPTH (4),
      .BIG_BYTES  (32'd4096),
      .CNT_W      (16)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .cmd_valid_i  (cmd_valid),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_op_i     (cmd_op),
      .cmd_data_i   (cmd_data),
      .wr_ready_i   (wr_ready),
      .en_write_o   (en_write_o),
      .rec_valid_o  (rec_valid_o),
      .addr_first_o (addr_first_o),
      .addr_last_o  (addr_last_o),
      .is_big_o     (is_big_o),
      .busy_o       (busy_o),
      .err_o        (err_o),
      .err_code_o   (err_code_o),
      .rec_count_o  (rec_count_o),
      .drop_count_o (drop_count_o)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] f;
      logic [31:0] l;
      logic        big;
   } mrec_t;

   mrec_t       mq[$];
   mrec_t       mhold;
   bit          m_have;
   logic [31:0] m_first;
   bit          m_err;
   logic [1:0]  m_code;
   int          m_rec, m_drop;
   bit          m_acc;

   function automatic mrec_t mk(input logic [31:0] f, input logic [31:0] l);
      mrec_t r;
      longint len;
      len   = longint'(l) - longint'(f) + 1;
      r.f   = f;
      r.l   = l;
      r.big = (len > 4096);
      return r;
   endfunction

   task automatic m_error(input logic [1:0] c);
      m_err  = 1'b1;
      m_code = c;
      if (m_drop < 65535) m_drop++;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         mhold   = '{f: '0, l: '0, big: 1'b0};
         m_have  = 1'b0;
         m_first = '0;
         m_err   = 1'b0;
         m_code  = 2'd0;
         m_rec   = 0;
         m_drop  = 0;
      end else begin
         m_acc = cmd_valid && (mq.size() < 4);
         m_err = 1'b0;
         if (mq.size() > 0 && wr_ready) begin
            mhold = mq.pop_front();
            if (m_rec < 65535) m_rec++;
         end
         if (m_acc) begin
            case (cmd_op)
               2'd0: begin m_first = cmd_data; m_have = 1'b1; end
               2'd1: begin
                  if (!m_have) m_error(2'd1);
                  else if (cmd_data < m_first) m_error(2'd2);
                  else mq.push_back(mk(m_first, cmd_data));
                  m_have = 1'b0;
               end
               2'd2: begin
                  if (!m_have) m_error(2'd1);
                  else if (cmd_data == 0 ||
                           (longint'(m_first) + longint'(cmd_data) - 1) > 64'hFFFF_FFFF)
                     m_error(2'd3);
                  else mq.push_back(mk(m_first, m_first + cmd_data - 32'd1));
                  m_have = 1'b0;
               end
               default: m_have = 1'b0;
            endcase
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      mrec_t h;
      bit    v;
      v = (mq.size() > 0);
      if (v) h = mq[0];
      else   h = mhold;
      chk("cmd_ready",  {31'd0, cmd_ready_o}, {31'd0, mq.size() < 4});
      chk("rec_valid",  {31'd0, rec_valid_o}, {31'd0, v});
      chk("en_write",   {31'd0, en_write_o},  {31'd0, v && wr_ready});
      chk("addr_first", addr_first_o, h.f);
      chk("addr_last",  addr_last_o,  h.l);
      chk("is_big",     {31'd0, is_big_o},    {31'd0, h.big});
      chk("busy",       {31'd0, busy_o},      {31'd0, m_have || v});
      chk("err",        {31'd0, err_o},       {31'd0, m_err});
      chk("err_code",   {30'd0, err_code_o},  {30'd0, m_code});
      chk("rec_count",  {16'd0, rec_count_o}, m_rec);
      chk("drop_count", {16'd0, drop_count_o}, m_drop);
   end

   // ---------------- stimulus ----------------
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (wr_mode)
            0:       wr_ready = 1'b0;
            1:       wr_ready = 1'b1;
            default: wr_ready = ($urandom_range(0, 2) != 0);
         endcase
      end
   end

   task automatic send(input logic [1:0] op, input logic [31:0] d);
      bit done;
      done      = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         done = cmd_ready_o;
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      if (!done) begin
         n_checks++;
         n_errs++;
         $display("FAIL send_timeout: got no accept expected accept op=%0d", op);
      end
   endtask

   logic [31:0] sf;

   initial begin
      wr_mode = 1;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", {31'd0, cmd_ready_o}, 32'd1);
      chk("rst_rec_count", {16'd0, rec_count_o}, 32'd0);
      @(posedge clk); #1;

      // 1: basic size descriptor
      send(2'd0, 32'h1000);
      send(2'd2, 32'h100);
      @(negedge clk);
      chk("t1_en_write", {31'd0, en_write_o}, 32'd1);
      chk("t1_first", addr_first_o, 32'h1000);
      chk("t1_last", addr_last_o, 32'h10FF);
      chk("t1_big", {31'd0, is_big_o}, 32'd0);
      @(negedge clk);
      chk("t1_rec_count", {16'd0, rec_count_o}, 32'd1);
      @(posedge clk); #1;

      // 2: big flag boundaries
      send(2'd0, 32'h8000_0000);
      send(2'd1, 32'h8000_2000);
      @(negedge clk);
      chk("t2_last", addr_last_o, 32'h8000_2000);
      chk("t2_big", {31'd0, is_big_o}, 32'd1);
      @(posedge clk); #1;
      send(2'd0, 32'h0);
      send(2'd2, 32'h1000);
      @(negedge clk);
      chk("t2b_last", addr_last_o, 32'h0FFF);
      chk("t2b_big", {31'd0, is_big_o}, 32'd0);
      @(posedge clk); #1;

      // 3: error cases
      send(2'd1, 32'h10);
      @(negedge clk);
      chk("t3_err1", {31'd0, err_o}, 32'd1);
      chk("t3_code1", {30'd0, err_code_o}, 32'd1);
      @(posedge clk); #1;
      send(2'd0, 32'h20);
      send(2'd1, 32'h1F);
      @(negedge clk);
      chk("t3_code2", {30'd0, err_code_o}, 32'd2);
      @(posedge clk); #1;
      send(2'd0, 32'hFFFF_FFF0);
      send(2'd2, 32'h20);
      @(negedge clk);
      chk("t3_code3", {30'd0, err_code_o}, 32'd3);
      @(posedge clk); #1;
      send(2'd0, 32'h100);
      send(2'd2, 32'h0);
      @(negedge clk);
      chk("t3_code3z", {30'd0, err_code_o}, 32'd3);
      chk("t3_drop", {16'd0, drop_count_o}, 32'd4);
      @(posedge clk); #1;

      // 4: backpressure, full queue stalls the fifth descriptor
      wr_mode = 0;
      repeat (2) @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         send(2'd0, 32'h100 * (i + 1));
         send(2'd2, 32'h10);
      end
      @(negedge clk);
      chk("t4_full_ready", {31'd0, cmd_ready_o}, 32'd0);
      @(posedge clk); #1;
      fork
         begin
            send(2'd0, 32'h500);
            send(2'd2, 32'h10);
         end
         begin
            repeat (6) @(posedge clk);
            wr_mode = 1;
         end
      join
      repeat (10) @(negedge clk);
      chk("t4_rec_count", {16'd0, rec_count_o}, 32'd8);
      @(posedge clk); #1;

      // 5: abort and first-replacement
      send(2'd0, 32'h40);
      send(2'd3, 32'h0);
      send(2'd2, 32'h4);
      @(negedge clk);
      chk("t5_err", {31'd0, err_o}, 32'd1);
      chk("t5_code", {30'd0, err_code_o}, 32'd1);
      @(posedge clk); #1;
      send(2'd0, 32'h40);
      send(2'd0, 32'h80);
      send(2'd2, 32'h4);
      @(negedge clk);
      chk("t5_first", addr_first_o, 32'h80);
      chk("t5_last", addr_last_o, 32'h83);
      @(posedge clk); #1;

      // 6: reset with queued records and a pending first
      wr_mode = 0;
      repeat (2) @(posedge clk); #1;
      send(2'd0, 32'h1000); send(2'd2, 32'h8);
      send(2'd0, 32'h2000); send(2'd1, 32'h2010);
      send(2'd0, 32'h3000);
      @(negedge clk);
      chk("t6_pre_valid", {31'd0, rec_valid_o}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("t6_valid", {31'd0, rec_valid_o}, 32'd0);
      chk("t6_busy", {31'd0, busy_o}, 32'd0);
      chk("t6_rec_count", {16'd0, rec_count_o}, 32'd0);
      chk("t6_drop", {16'd0, drop_count_o}, 32'd0);
      wr_mode = 1;
      @(negedge clk);
      #2 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t6_no_write", {31'd0, en_write_o}, 32'd0);
      end
      @(posedge clk); #1;

      // random phase
      wr_mode = 2;
      sf = '0;
      for (int n = 0; n < 800; n++) begin
         int sel;
         logic [1:0] op;
         logic [31:0] d;
         sel = $urandom_range(0, 9);
         if (sel < 4) begin
            op = 2'd0;
            d  = ($urandom_range(0, 4) == 0) ? (32'hFFFF_F000 + $urandom_range(0, 4095)) : $urandom;
            sf = d;
         end else if (sel < 6) begin
            op = 2'd1;
            d  = ($urandom_range(0, 3) == 0) ? $urandom : sf + $urandom_range(0, 8192);
         end else if (sel < 9) begin
            op = 2'd2;
            d  = ($urandom_range(0, 5) == 0) ? $urandom : $urandom_range(0, 9000);
         end else begin
            op = 2'd3;
            d  = $urandom;
         end
         send(op, d);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      wr_mode = 1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule

// File: doc/bounds_record_writer.md
Name: bounds_record_writer

Overview:
- Producer side of the bounds-tracking circular buffer's write interface.
- Takes allocation descriptors from the core as a command stream: first address, then either last address or byte size.
- Validates each descriptor, computes last address and the is_big flag, and queues finished records.
- Drives them as en_write/first/last/is_big write pulses toward the buffer. Keeps error and accounting counters for the memory-safety monitor.

Parameters:
FIFO_DEPTH, 4, record queue entries (power of two, ≥2)
BIG_BYTES, 32'd4096, a range is "big" when its byte length is strictly greater than this
CNT_W, 16, width of saturating record/drop counters

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_op_i  in  2  0=SET_FIRST, 1=SET_LAST, 2=SET_SIZE, 3=ABORT
cmd_data_i  in  32  address or size operand
wr_ready_i  in  1  buffer side can take a record this cycle
en_write_o  out  1  write strobe to buffer (= record valid & wr_ready_i)
rec_valid_o  out  1  queue head holds a record
addr_first_o  out  32  head record first address
addr_last_o  out  32  head record last address (inclusive)
is_big_o  out  1  head record big flag
busy_o  out  1  FSM in HAVE_FIRST or queue non-empty
err_o  out  1  one-cycle error pulse
err_code_o  out  2  last error: 0=NONE, 1=NO_FIRST, 2=INVERTED, 3=ZERO_OR_WRAP
rec_count_o  out  CNT_W  records written to buffer, saturating
drop_count_o  out  CNT_W  descriptors dropped on error, saturating

Behaviour:
- Reset (async, rst_i=1):
  - FSM=IDLE, queue empty, first register=0.
  - err_o=0, err_code_o=0, both counters=0.
  - rec_valid_o=0, en_write_o=0; addr_first_o, addr_last_o, is_big_o=0.
  - cmd_ready_o=1.
  - Reset mid-descriptor or with a non-empty queue discards everything. No write is emitted.
- cmd_ready_o = ~queue_full, combinational from the queue count. A command is accepted only on cmd_valid_i & cmd_ready_o.
- FSM states IDLE and HAVE_FIRST. All transitions apply on accepted commands only.
  - SET_FIRST (either state): first<=data, go to HAVE_FIRST. A repeated SET_FIRST silently replaces the stored address.
  - SET_LAST in HAVE_FIRST:
    - data < first: error INVERTED, drop.
    - otherwise push {first, data}.
    - Either way go to IDLE.
  - SET_SIZE in HAVE_FIRST:
    - data==0, or first+data-1 carries out of 32 bits (33-bit add): error ZERO_OR_WRAP, drop.
    - otherwise push {first, first+data-1}.
    - Either way go to IDLE.
  - SET_LAST or SET_SIZE in IDLE: error NO_FIRST, drop, stay IDLE.
  - ABORT: go to IDLE, no error, no count change.
- is_big = (last - first) >= BIG_BYTES, evaluated in 32 bits; last ≥ first is guaranteed.
- On error:
  - err_o=1 in the cycle after acceptance.
  - err_code_o updates in that same cycle and holds until the next error.
  - drop_count_o increments, saturating at all-ones.
- Queue:
  - Registered FIFO; head drives addr_first_o, addr_last_o, is_big_o.
  - rec_valid_o = ~empty.
  - Push happens in the acceptance cycle. The record is visible on rec_valid_o the next cycle (latency 1).
  - Pop on en_write_o = rec_valid_o & wr_ready_i. rec_count_o increments on each pop, saturating.
  - Simultaneous push and pop: count unchanged, order preserved.
  - When full, cmd_ready_o=0 but pop still proceeds. cmd_ready_o rises the cycle after the pop.
  - Read and write pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit.
  - Head outputs hold their value while empty; they are not cleared.

Decomposition:
- Shared package bounds_pkg holds:
  - cmd_op_e (SET_FIRST, SET_LAST, SET_SIZE, ABORT)
  - err_code_e (NONE, NO_FIRST, INVERTED, ZERO_OR_WRAP)
  - bounds_rec_t struct {first[31:0], last[31:0], is_big}
  - DEFAULT_BIG_BYTES constant
- One sub-module: bounds_rec_fifo, a synchronous FIFO of bounds_rec_t with push/pop/full/empty, async active-high reset.

Test Plan:
1. SET_FIRST 0x1000, SET_SIZE 0x100, wr_ready_i=1 -> one cycle later en_write_o=1 with first=0x1000, last=0x10FF, is_big=0; rec_count_o=1.
2. SET_FIRST 0x8000_0000, SET_LAST 0x8000_2000 -> record last=0x8000_2000, is_big=1 (length 0x2001 > 4096). SET_SIZE 0x1000 from first 0 -> is_big=0 (length exactly 4096).
3. Error cases:
   - SET_LAST 0x10 in IDLE -> err_o pulse, err_code_o=1.
   - SET_FIRST 0x20, SET_LAST 0x1F -> err_code_o=2.
   - SET_FIRST 0xFFFF_FFF0, SET_SIZE 0x20 -> err_code_o=3.
   - SET_SIZE 0 -> err_code_o=3.
   - drop_count_o=4, no en_write_o in any case.
4. wr_ready_i=0, five complete descriptors -> after 4 pushes cmd_ready_o=0 and the fifth command stalls. Raise wr_ready_i -> records drain in order, fifth accepted, rec_count_o=5.
5. SET_FIRST 0x40, ABORT, SET_SIZE 4 -> NO_FIRST error, no record. SET_FIRST 0x40, SET_FIRST 0x80, SET_SIZE 4 -> record 0x80..0x83.
6. Assert rst_i with 2 queued records and FSM in HAVE_FIRST -> immediately rec_valid_o=0, busy_o=0, counters 0, no en_write_o after release.
